// File: rtl/muon_buffer_writer.sv
// Muon event writer: stores a header (index, timestamp) and a sample burst per trigger
// into BRAM, then hands the whole buffer to DMA once it is full.
module muon_buffer_writer #(
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned MAX_EVENTS = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic        TRIG,
  input  logic [31:0] DATA_IN,
  input  logic [31:0] TIME_IN,
  input  logic        DMA_DONE,
  output logic [16:0] ADDR_A,
  output logic        ENA_A,
  output logic [3:0]  WE_A,
  output logic [31:0] DOUT,
  output logic        SEL_B,
  output logic        FULL,
  output logic [15:0] NEVENTS,
  output logic [15:0] LOST_CNT
);

  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StSamples,
    StCheck,
    StHandoff
  } state_e;

  localparam int unsigned CntW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CntW-1:0] LastSample = CntW'(BURST_LEN - 1);
  localparam logic [17:0] EventWords = 18'(BURST_LEN + 2);
  localparam logic [17:0] AddrLimit = 18'h20000;
  localparam logic [15:0] MaxEvents = 16'(MAX_EVENTS);

  state_e          state_q, state_d;
  logic [CntW-1:0] smp_q, smp_d;
  logic [15:0]     count_q, count_d;
  logic [31:0]     ts_q, ts_d;
  logic [16:0]     addr_q, addr_d;
  logic            ena_q, ena_d;
  logic [3:0]      we_q, we_d;
  logic [31:0]     dout_q, dout_d;
  logic            sel_q, sel_d;
  logic            full_q, full_d;
  logic [15:0]     nev_q, nev_d;
  logic [15:0]     lost_q, lost_d;
  // High for the first cycle after reset releases; a trigger then is ignored.
  logic            rst_prev_q;

  logic        trig_ok;
  logic [15:0] count_inc;
  logic        fits;

  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    count_d = count_q;
    ts_d    = ts_q;
    addr_d  = addr_q;
    ena_d   = 1'b0;
    dout_d  = dout_q;
    sel_d   = sel_q;
    full_d  = full_q;
    nev_d   = nev_q;
    lost_d  = lost_q;

    trig_ok   = TRIG && ENABLE && !rst_prev_q;
    count_inc = count_q + 16'd1;
    // The next event needs EventWords addresses starting at the current write pointer.
    fits      = ({1'b0, addr_q} + EventWords) <= AddrLimit;

    if (ena_q) begin
      addr_d = addr_q + 17'd1;
    end
    if (TRIG && (state_q != StIdle) && (lost_q != 16'hFFFF)) begin
      lost_d = lost_q + 16'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (trig_ok) begin
          state_d = StHdr0;
          ts_d    = TIME_IN;
          ena_d   = 1'b1;
          dout_d  = {16'h0, count_q};
        end
      end
      StHdr0: begin
        state_d = StHdr1;
        ena_d   = 1'b1;
        dout_d  = ts_q;
      end
      StHdr1: begin
        state_d = StSamples;
        smp_d   = '0;
        ena_d   = 1'b1;
        dout_d  = DATA_IN;
      end
      StSamples: begin
        if (smp_q == LastSample) begin
          state_d = StCheck;
        end else begin
          smp_d  = smp_q + 1'b1;
          ena_d  = 1'b1;
          dout_d = DATA_IN;
        end
      end
      StCheck: begin
        count_d = count_inc;
        if ((count_inc == MaxEvents) || !fits) begin
          state_d = StHandoff;
          sel_d   = 1'b1;
          full_d  = 1'b1;
          nev_d   = count_inc;
        end else begin
          state_d = StIdle;
        end
      end
      StHandoff: begin
        if (DMA_DONE) begin
          state_d = StIdle;
          sel_d   = 1'b0;
          full_d  = 1'b0;
          nev_d   = 16'h0;
          addr_d  = 17'h0;
          count_d = 16'h0;
        end
      end
      default: state_d = StIdle;
    endcase

    we_d = {4{ena_d}};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      smp_q      <= '0;
      count_q    <= 16'h0;
      ts_q       <= 32'h0;
      addr_q     <= 17'h0;
      ena_q      <= 1'b0;
      we_q       <= 4'h0;
      dout_q     <= 32'h0;
      sel_q      <= 1'b0;
      full_q     <= 1'b0;
      nev_q      <= 16'h0;
      lost_q     <= 16'h0;
      rst_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      smp_q      <= smp_d;
      count_q    <= count_d;
      ts_q       <= ts_d;
      addr_q     <= addr_d;
      ena_q      <= ena_d;
      we_q       <= we_d;
      dout_q     <= dout_d;
      sel_q      <= sel_d;
      full_q     <= full_d;
      nev_q      <= nev_d;
      lost_q     <= lost_d;
      rst_prev_q <= 1'b0;
    end
  end

  assign ADDR_A   = addr_q;
  assign ENA_A    = ena_q;
  assign WE_A     = we_q;
  assign DOUT     = dout_q;
  assign SEL_B    = sel_q;
  assign FULL     = full_q;
  assign NEVENTS  = nev_q;
  assign LOST_CNT = lost_q;

endmodule

// File: tb/tb_muon_buffer_writer.sv
// Directed bench for muon_buffer_writer: events, handoff, lost/disabled triggers, reset, saturation.
module tb_muon_buffer_writer;

  localparam int unsigned BL = 16;
  localparam int unsigned ME = 4;

  logic        CLK = 1'b0;
  logic        RST, ENABLE, TRIG, DMA_DONE;
  logic [31:0] DATA_IN, TIME_IN;
  logic [16:0] ADDR_A;
  logic        ENA_A;
  logic [3:0]  WE_A;
  logic [31:0] DOUT;
  logic        SEL_B, FULL;
  logic [15:0] NEVENTS, LOST_CNT;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  muon_buffer_writer #(
    .BURST_LEN  (BL),
    .MAX_EVENTS (ME)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ENABLE   (ENABLE),
    .TRIG     (TRIG),
    .DATA_IN  (DATA_IN),
    .TIME_IN  (TIME_IN),
    .DMA_DONE (DMA_DONE),
    .ADDR_A   (ADDR_A),
    .ENA_A    (ENA_A),
    .WE_A     (WE_A),
    .DOUT     (DOUT),
    .SEL_B    (SEL_B),
    .FULL     (FULL),
    .NEVENTS  (NEVENTS),
    .LOST_CNT (LOST_CNT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] dval(input int c);
    return 32'hD000_0000 + 32'(c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs set after an edge apply at the following edge; outputs read here are post-edge.
  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    DATA_IN = dval(cyc);
  endtask

  task automatic run_event(input logic [31:0] ts, input logic [15:0] idx, input logic [16:0] base,
                           input bit drop_en, input bit lose);
    TIME_IN = ts;
    TRIG = 1'b1;
    step();
    TRIG = 1'b0;
    TIME_IN = 32'hFFFF_0000;
    chk("hdr0_ena", 32'(ENA_A), 32'd1);
    chk("hdr0_we", 32'(WE_A), 32'hF);
    chk("hdr0_addr", 32'(ADDR_A), 32'(base));
    chk("hdr0_dout", DOUT, {16'h0, idx});
    step();
    if (drop_en) ENABLE = 1'b0;
    chk("hdr1_ena", 32'(ENA_A), 32'd1);
    chk("hdr1_addr", 32'(ADDR_A), 32'(base) + 32'd1);
    chk("hdr1_dout", DOUT, ts);
    for (int i = 0; i < int'(BL); i++) begin
      if (lose && i == 5) TRIG = 1'b1;
      step();
      TRIG = 1'b0;
      chk("smp_ena", 32'(ENA_A), 32'd1);
      chk("smp_addr", 32'(ADDR_A), 32'(base) + 32'd2 + 32'(i));
      chk("smp_dout", DOUT, dval(cyc - 1));
    end
    step();
    chk("check_ena", 32'(ENA_A), 32'd0);
    chk("check_we", 32'(WE_A), 32'd0);
    chk("check_addr", 32'(ADDR_A), 32'(base) + 32'(BL) + 32'd2);
  endtask

  initial begin
    RST = 1'b1; ENABLE = 1'b0; TRIG = 1'b0; DMA_DONE = 1'b0;
    DATA_IN = 32'h0; TIME_IN = 32'h0;
    step();
    step();
    chk("rst_addr", 32'(ADDR_A), 32'd0);
    chk("rst_ena", 32'(ENA_A), 32'd0);
    chk("rst_we", 32'(WE_A), 32'd0);
    chk("rst_dout", DOUT, 32'd0);
    chk("rst_sel", 32'(SEL_B), 32'd0);
    chk("rst_full", 32'(FULL), 32'd0);
    chk("rst_nev", 32'(NEVENTS), 32'd0);
    chk("rst_lost", 32'(LOST_CNT), 32'd0);

    // Trigger in the cycle reset is released is ignored
    RST = 1'b0; ENABLE = 1'b1; TRIG = 1'b1;
    step();
    TRIG = 1'b0;
    chk("rstrel_ena", 32'(ENA_A), 32'd0);
    step();
    chk("rstrel_ena2", 32'(ENA_A), 32'd0);
    chk("rstrel_lost", 32'(LOST_CNT), 32'd0);

    // Disabled triggers in IDLE
    ENABLE = 1'b0;
    repeat (3) begin
      TRIG = 1'b1;
      step();
      TRIG = 1'b0;
      chk("dis_ena", 32'(ENA_A), 32'd0);
      step();
    end
    chk("dis_lost", 32'(LOST_CNT), 32'd0);
    chk("dis_addr", 32'(ADDR_A), 32'd0);
    ENABLE = 1'b1;
    step();

    // Event 0 with one trigger lost during SAMPLES
    run_event(32'h0000_1234, 16'd0, 17'd0, 1'b0, 1'b1);
    chk("ev0_lost", 32'(LOST_CNT), 32'd1);
    chk("ev0_full", 32'(FULL), 32'd0);
    step();
    step();
    // ENABLE drops during HDR1; event still completes
    run_event(32'hABCD_0001, 16'd1, 17'd18, 1'b1, 1'b0);
    step();
    ENABLE = 1'b1;
    step();
    run_event(32'h0000_2222, 16'd2, 17'd36, 1'b0, 1'b0);
    step();
    run_event(32'h0000_3333, 16'd3, 17'd54, 1'b0, 1'b0);
    step();
    chk("ho_full", 32'(FULL), 32'd1);
    chk("ho_sel", 32'(SEL_B), 32'd1);
    chk("ho_nev", 32'(NEVENTS), 32'd4);
    chk("ho_addr", 32'(ADDR_A), 32'd72);
    chk("ho_ena", 32'(ENA_A), 32'd0);

    // Triggers in HANDOFF are lost; the last coincides with DMA_DONE
    repeat (4) begin
      TRIG = 1'b1;
      step();
    end
    chk("ho_lost5", 32'(LOST_CNT), 32'd5);
    chk("ho_ena2", 32'(ENA_A), 32'd0);
    chk("ho_addr2", 32'(ADDR_A), 32'd72);
    chk("ho_full2", 32'(FULL), 32'd1);
    DMA_DONE = 1'b1;
    step();
    TRIG = 1'b0;
    DMA_DONE = 1'b0;
    chk("dma_lost6", 32'(LOST_CNT), 32'd6);
    chk("dma_sel", 32'(SEL_B), 32'd0);
    chk("dma_full", 32'(FULL), 32'd0);
    chk("dma_nev", 32'(NEVENTS), 32'd0);
    chk("dma_addr", 32'(ADDR_A), 32'd0);
    chk("dma_ena", 32'(ENA_A), 32'd0);
    step();
    chk("dma_ena2", 32'(ENA_A), 32'd0);

    // DMA_DONE in IDLE is ignored
    DMA_DONE = 1'b1;
    step();
    DMA_DONE = 1'b0;
    chk("idle_dma_sel", 32'(SEL_B), 32'd0);
    chk("idle_dma_lost", 32'(LOST_CNT), 32'd6);

    // Reset in the middle of SAMPLES
    TIME_IN = 32'h0000_5555;
    TRIG = 1'b1;
    step();
    TRIG = 1'b0;
    chk("pre_rst_idx", DOUT, 32'd0);
    step();
    repeat (8) step();
    chk("pre_rst_addr", 32'(ADDR_A), 32'd9);
    RST = 1'b1;
    step();
    chk("mid_rst_ena", 32'(ENA_A), 32'd0);
    chk("mid_rst_addr", 32'(ADDR_A), 32'd0);
    chk("mid_rst_dout", DOUT, 32'd0);
    chk("mid_rst_lost", 32'(LOST_CNT), 32'd0);
    RST = 1'b0;
    step();
    step();
    run_event(32'h0000_6666, 16'd0, 17'd0, 1'b0, 1'b0);
    step();
    run_event(32'h0000_7777, 16'd1, 17'd18, 1'b0, 1'b0);
    step();
    run_event(32'h0000_8888, 16'd2, 17'd36, 1'b0, 1'b0);
    step();
    run_event(32'h0000_9999, 16'd3, 17'd54, 1'b0, 1'b0);
    step();
    chk("ho2_full", 32'(FULL), 32'd1);
    chk("ho2_nev", 32'(NEVENTS), 32'd4);

    // Saturation of the lost-trigger counter
    TRIG = 1'b1;
    repeat (65540) step();
    TRIG = 1'b0;
    chk("sat_lost", 32'(LOST_CNT), 32'hFFFF);
    chk("sat_full", 32'(FULL), 32'd1);
    DMA_DONE = 1'b1;
    step();
    DMA_DONE = 1'b0;
    chk("sat_dma_full", 32'(FULL), 32'd0);
    chk("sat_dma_lost", 32'(LOST_CNT), 32'hFFFF);
    DMA_DONE = 1'b1;
    step();
    DMA_DONE = 1'b0;
    chk("sat_idle_sel", 32'(SEL_B), 32'd0);
    chk("sat_idle_addr", 32'(ADDR_A), 32'd0);
    chk("sat_idle_nev", 32'(NEVENTS), 32'd0);
    chk("sat_idle_lost", 32'(LOST_CNT), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
